// File: rtl/instr_encoder_loader.sv
// Instruction encoder and loader. It takes decoded RV32I field bundles over a
// valid/ready handshake, packs each one into a 32-bit instruction word, and
// writes the words to consecutive instruction-memory locations starting at
// address 0.
module instr_encoder_loader #(
    parameter int unsigned ADDR_WIDTH   = 6,
    parameter int unsigned OPCODE_WIDTH = 7,
    parameter int unsigned FUNCT7_WIDTH = 7,
    parameter int unsigned FUNCT3_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [FUNCT3_WIDTH-1:0] funct3,
    input  logic [FUNCT7_WIDTH-1:0] funct7,
    input  logic [4:0]              rd,
    input  logic [4:0]              rs1,
    input  logic [4:0]              rs2,
    input  logic [31:0]             imm,
    input  logic                    last,
    output logic                    imem_we,
    output logic [ADDR_WIDTH+1:0]   imem_addr,
    output logic [31:0]             imem_wdata,
    output logic                    busy,
    output logic                    done,
    output logic                    full,
    output logic                    err_illegal,
    output logic [ADDR_WIDTH:0]     count
);

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;

    typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_e;

    state_e              state_q;
    // One bit wider than the address so it can report a completely full memory.
    logic [ADDR_WIDTH:0] ptr_q;
    logic                we_q;
    logic [31:0]         wdata_q;
    logic                full_q;
    logic                err_q;
    logic                last_q;

    logic [31:0]         enc_word;
    logic                enc_legal;

    // Pack the incoming fields into an RV32I word; flag unsupported opcodes.
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (opcode)
            OpR: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
            OpImm: begin
                // Shift-immediate forms carry funct7 in the upper bits.
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    enc_word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                end else begin
                    enc_word = {imm[11:0], rs1, funct3, rd, opcode};
                end
            end
            OpLoad, OpJalr: enc_word = {imm[11:0], rs1, funct3, rd, opcode};
            OpStore:  enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            OpBranch: enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11],
                                  opcode};
            OpLui, OpAuipc: enc_word = {imm[31:12], rd, opcode};
            OpJal: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: enc_legal = 1'b0;
        endcase
    end

    // Load FSM with registered write strobe, data, pointer and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (start) begin
                state_q <= StLoad;
                ptr_q   <= '0;
                full_q  <= 1'b0;
                err_q   <= 1'b0;
                last_q  <= 1'b0;
            end else begin
                case (state_q)
                    StLoad: begin
                        if (in_valid) begin
                            last_q <= last;
                            if (enc_legal) begin
                                we_q    <= 1'b1;
                                wdata_q <= enc_word;
                                state_q <= StWrite;
                            end else begin
                                // Illegal bundle is consumed without a write.
                                err_q   <= 1'b1;
                                state_q <= last ? StDone : StLoad;
                            end
                        end
                    end
                    StWrite: begin
                        ptr_q <= ptr_q + 1'b1;
                        if (last_q) begin
                            state_q <= StDone;
                        end else if (ptr_q[ADDR_WIDTH-1:0] == '1) begin
                            // Top word just written: stop rather than wrap.
                            full_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            state_q <= StLoad;
                        end
                    end
                    StIdle, StDone: ;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign in_ready    = (state_q == StLoad);
    assign busy        = (state_q == StLoad) || (state_q == StWrite);
    assign done        = (state_q == StDone);
    assign imem_we     = we_q;
    assign imem_addr   = {ptr_q[ADDR_WIDTH-1:0], 2'b00};
    assign imem_wdata  = wdata_q;
    assign full        = full_q;
    assign err_illegal = err_q;
    assign count       = ptr_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: a default-size instance plus an
// ADDR_WIDTH=2 instance for the memory-full case.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        sel = 1'b0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [31:0] imm = '0;
    logic        last = 1'b0;

    logic        m_valid, m_ready, m_we, m_busy, m_done, m_full, m_err;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata;
    logic [6:0]  m_count;
    logic        s_valid, s_ready, s_we, s_busy, s_done, s_full, s_err;
    logic [3:0]  s_addr;
    logic [31:0] s_wdata;
    logic [2:0]  s_count;

    logic        c_ready, c_we, c_busy, c_done, c_full, c_err;
    logic [7:0]  c_count;

    int tests = 0;
    int fails = 0;
    logic [39:0] qm[$];
    logic [39:0] qs[$];

    always #5 clk = ~clk;

    assign m_valid = in_valid & ~sel;
    assign s_valid = in_valid & sel;

    instr_encoder_loader u_main (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(m_valid), .in_ready(m_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .last(last), .imem_we(m_we), .imem_addr(m_addr), .imem_wdata(m_wdata),
        .busy(m_busy), .done(m_done), .full(m_full), .err_illegal(m_err), .count(m_count)
    );

    instr_encoder_loader #(.ADDR_WIDTH(2)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(s_valid), .in_ready(s_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .last(last), .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata),
        .busy(s_busy), .done(s_done), .full(s_full), .err_illegal(s_err), .count(s_count)
    );

    assign c_ready = sel ? s_ready : m_ready;
    assign c_we    = sel ? s_we    : m_we;
    assign c_busy  = sel ? s_busy  : m_busy;
    assign c_done  = sel ? s_done  : m_done;
    assign c_full  = sel ? s_full  : m_full;
    assign c_err   = sel ? s_err   : m_err;
    assign c_count = sel ? {5'b0, s_count} : {1'b0, m_count};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Monitor: every write strobe pops the next expected {addr, data}.
    always @(negedge clk) begin
        logic [39:0] e;
        if (m_we) begin
            tests++;
            if (qm.size() == 0) begin
                fails++;
                $display("FAIL main_unexpected_write: got %h/%h required none", m_addr, m_wdata);
            end else begin
                e = qm.pop_front();
                if ({m_addr, m_wdata} !== e) begin
                    fails++;
                    $display("FAIL main_write: got %h/%h required %h/%h",
                             m_addr, m_wdata, e[39:32], e[31:0]);
                end
            end
        end
        if (s_we) begin
            tests++;
            if (qs.size() == 0) begin
                fails++;
                $display("FAIL small_unexpected_write: got %h/%h required none", s_addr, s_wdata);
            end else begin
                e = qs.pop_front();
                if ({4'b0, s_addr, s_wdata} !== e) begin
                    fails++;
                    $display("FAIL small_write: got %h/%h required %h/%h",
                             s_addr, s_wdata, e[39:32], e[31:0]);
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present a bundle until accepted or the bound expires; legal ones are
    // pushed to the scoreboard and must strobe imem_we the cycle after.
    task automatic send(input string nm, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] rdv, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [31:0] iv, input logic lst,
                        input logic legal, input logic [7:0] ea, input logic [31:0] ew,
                        input int bound, output logic acc);
        @(negedge clk);
        opcode = op; funct3 = f3; funct7 = f7; rd = rdv; rs1 = r1; rs2 = r2;
        imm = iv; last = lst; in_valid = 1'b1;
        if (legal) begin
            if (sel) qs.push_back({ea, ew});
            else     qm.push_back({ea, ew});
        end
        acc = 1'b0;
        for (int i = 0; i < bound && !acc; i++) begin
            if (c_ready) acc = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (acc) check($sformatf("%s_we_latency", nm), {31'b0, c_we}, {31'b0, legal});
    endtask

    task automatic send_ok(input string nm, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [4:0] rdv, input logic [4:0] r1,
                           input logic [4:0] r2, input logic [31:0] iv, input logic lst,
                           input logic legal, input logic [7:0] ea, input logic [31:0] ew);
        logic acc;
        send(nm, op, f3, f7, rdv, r1, r2, iv, lst, legal, ea, ew, 20, acc);
        check($sformatf("%s_accepted", nm), {31'b0, acc}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic acc;
        logic [31:0] small_words[4];
        small_words[0] = 32'h00000093;
        small_words[1] = 32'h00100113;
        small_words[2] = 32'h00200193;
        small_words[3] = 32'h00300213;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, m_ready}, 0);
        check("rst_busy",  {31'b0, m_busy}, 0);
        check("rst_done",  {31'b0, m_done}, 0);
        check("rst_full",  {31'b0, m_full}, 0);
        check("rst_err",   {31'b0, m_err}, 0);
        check("rst_we",    {31'b0, m_we}, 0);
        check("rst_count", {25'b0, m_count}, 0);
        check("rst_addr",  {24'b0, m_addr}, 0);
        check("rst_wdata", m_wdata, 0);
        rst_n = 1'b1;

        // No acceptance while idle.
        send("idle_hold", 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0,
             1'b0, 8'h0, 32'h0, 5, acc);
        check("idle_no_accept", {31'b0, acc}, 0);

        // Single R-type.
        pulse_start();
        check("t1_busy", {31'b0, m_busy}, 1);
        check("t1_ready", {31'b0, m_ready}, 1);
        send_ok("t1_add", 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0,
                1'b1, 8'h00, 32'h002081B3);
        @(negedge clk);
        check("t1_count", {24'b0, c_count}, 1);

        // Mixed formats ending in last.
        pulse_start();
        check("t2_count_cleared", {24'b0, c_count}, 0);
        send_ok("t2_addi", 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0,
                1'b1, 8'h00, 32'h00500093);
        send_ok("t2_sw", 7'b0100011, 3'b010, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0,
                1'b1, 8'h04, 32'h0020A423);
        send_ok("t2_beq", 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b0,
                1'b1, 8'h08, 32'hFE208EE3);
        send_ok("t2_jal", 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b0,
                1'b1, 8'h0C, 32'h008000EF);
        send_ok("t2_lui", 7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1,
                1'b1, 8'h10, 32'h123452B7);
        repeat (2) @(negedge clk);
        check("t2_done",  {31'b0, c_done}, 1);
        check("t2_count", {24'b0, c_count}, 5);
        check("t2_busy",  {31'b0, c_busy}, 0);
        check("t2_ready", {31'b0, c_ready}, 0);
        check("t2_full",  {31'b0, c_full}, 0);

        // Illegal opcode mid-stream, plus a shift-immediate.
        pulse_start();
        send_ok("t3_slli", 7'b0010011, 3'b001, 7'b0100000, 5'd1, 5'd2, 5'd0, 32'd3, 1'b0,
                1'b1, 8'h00, 32'h40311093);
        send_ok("t3_illegal", 7'b1111111, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0,
                1'b0, 8'h00, 32'h0);
        check("t3_err", {31'b0, c_err}, 1);
        check("t3_count", {24'b0, c_count}, 1);
        send_ok("t3_add", 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1,
                1'b1, 8'h04, 32'h002081B3);
        repeat (2) @(negedge clk);
        check("t3_done", {31'b0, c_done}, 1);
        check("t3_count_final", {24'b0, c_count}, 2);
        check("t3_err_sticky", {31'b0, c_err}, 1);

        // Held valid in DONE is ignored; start with valid clears and defers acceptance.
        send("done_hold", 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0,
             1'b0, 8'h0, 32'h0, 5, acc);
        check("done_no_accept", {31'b0, acc}, 0);
        @(negedge clk);
        opcode = 7'b0110011; funct3 = 3'd0; funct7 = 7'd0; rd = 5'd3; rs1 = 5'd1; rs2 = 5'd2;
        imm = 32'd0; last = 1'b0; in_valid = 1'b1; start = 1'b1;
        qm.push_back({8'h00, 32'h002081B3});
        @(negedge clk);
        start = 1'b0;
        check("t5_err_cleared", {31'b0, c_err}, 0);
        check("t5_done_cleared", {31'b0, c_done}, 0);
        check("t5_count_cleared", {24'b0, c_count}, 0);
        check("t5_not_taken_at_start", {31'b0, c_ready}, 1);
        check("t5_no_we", {31'b0, c_we}, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("t5_we_after", {31'b0, c_we}, 1);
        @(negedge clk);
        check("t5_count", {24'b0, c_count}, 1);

        // Small memory fills up.
        sel = 1'b1;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            send_ok($sformatf("t4_w%0d", i), 7'b0010011, 3'd0, 7'd0, 5'(i + 1), 5'd0, 5'd0,
                    32'(i), 1'b0, 1'b1, 8'(i * 4), small_words[i]);
        end
        send("t4_fifth", 7'b0010011, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'd4, 1'b0,
             1'b0, 8'h0, 32'h0, 6, acc);
        check("t4_fifth_rejected", {31'b0, acc}, 0);
        check("t4_full",  {31'b0, c_full}, 1);
        check("t4_done",  {31'b0, c_done}, 1);
        check("t4_count", {24'b0, c_count}, 4);
        check("t4_ready", {31'b0, c_ready}, 0);
        sel = 1'b0;

        // Reset during a write.
        pulse_start();
        send_ok("t6_a", 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0,
                1'b1, 8'h00, 32'h002081B3);
        send_ok("t6_b", 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0,
                1'b1, 8'h04, 32'h00500093);
        #2 rst_n = 1'b0;
        #1;
        check("t6_we_async", {31'b0, m_we}, 0);
        check("t6_busy", {31'b0, m_busy}, 0);
        check("t6_ready", {31'b0, m_ready}, 0);
        check("t6_count", {25'b0, m_count}, 0);
        check("t6_addr", {24'b0, m_addr}, 0);
        check("t6_wdata", m_wdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        send_ok("t6_after", 7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1,
                1'b1, 8'h00, 32'h123452B7);
        repeat (3) @(negedge clk);

        check("main_queue_drained", qm.size(), 0);
        check("small_queue_drained", qs.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
